// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream FIFO write-side ingress stage.
package axis_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32;
  localparam int TLAST_BIT      = FIFO_WIDTH_DEF;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  function automatic logic [FIFO_WIDTH_DEF:0] pack_word(
    input logic [FIFO_WIDTH_DEF-1:0] tdata,
    input logic                      tlast
  );
    logic [FIFO_WIDTH_DEF:0] w;
    w                       = '0;
    w[TLAST_BIT]            = tlast;
    w[FIFO_WIDTH_DEF-1:0]   = tdata;
    return w;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with registered ready; the head drains into the FIFO
// write port whenever the write-pointer logic is not full.
module axis_skid_buf
  import axis_fifo_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         full_i,
  output logic         wr_en_o,
  output logic [W-1:0] out_data_o
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         rdy_q, rdy_d;
  logic         accept, pop;

  assign accept = in_valid_i & rdy_q;
  assign pop    = (state_q != EMPTY) & ~full_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        head_d  = in_data_i;
        state_d = ONE;
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_data_i;
        end else if (accept) begin
          tail_d  = in_data_i;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      // ready is low while in TWO, so only a pop can happen here
      TWO: if (pop) begin
        head_d  = tail_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready_o = rdy_q;
  assign wr_en_o    = pop;
  assign out_data_o = (state_q == EMPTY) ? '0 : head_q;

endmodule

// File: rtl/axis_fifo_wr_if.sv
// AXI4-Stream slave ingress to the FIFO write side: packs tlast above tdata,
// tracks packet framing, and with AXIS_WR_STATS_EN defined adds beat/packet counters.
module axis_fifo_wr_if
  import axis_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  w_clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  full,
  output logic                  wr_en,
  output logic [FIFO_WIDTH:0]   w_data,
  output logic                  pkt_open
`ifdef AXIS_WR_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
`endif
);

  logic [FIFO_WIDTH:0] in_word;
  logic                accept;
  logic                pkt_open_q;

  generate
    if (FIFO_WIDTH == FIFO_WIDTH_DEF) begin : g_pack_fn
      assign in_word = pack_word(s_axis_tdata, s_axis_tlast);
    end else begin : g_pack_cat
      assign in_word = {s_axis_tlast, s_axis_tdata};
    end
  endgenerate

  axis_skid_buf #(.W(FIFO_WIDTH + 1)) u_skid (
    .clk_i      (w_clk),
    .rst_i      (rst),
    .in_data_i  (in_word),
    .in_valid_i (s_axis_tvalid),
    .in_ready_o (s_axis_tready),
    .full_i     (full),
    .wr_en_o    (wr_en),
    .out_data_o (w_data)
  );

  assign accept = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge w_clk) begin
    if (rst)         pkt_open_q <= 1'b0;
    else if (accept) pkt_open_q <= ~s_axis_tlast;
  end

  assign pkt_open = pkt_open_q;

`ifdef AXIS_WR_STATS_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q, pkt_cnt_q;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
      if (s_axis_tlast) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_fifo_wr_if.sv
// Scoreboard bench for axis_fifo_wr_if: accepted beats are queued, FIFO writes pop and compare.
module tb_axis_fifo_wr_if;

  localparam int FW = 32;
  localparam int CW = 16;

  logic          w_clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          full = 1'b0;
  logic          wr_en;
  logic [FW:0]   w_data;
  logic          pkt_open;
`ifdef AXIS_WR_STATS_EN
  logic [CW-1:0] beat_cnt, pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int max_sb = 0;
  int writes = 0;
  logic [FW:0] sb[$];

  always #5 w_clk = ~w_clk;

  axis_fifo_wr_if #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .w_clk         (w_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .full          (full),
    .wr_en         (wr_en),
    .w_data        (w_data),
    .pkt_open      (pkt_open)
`ifdef AXIS_WR_STATS_EN
    ,
    .beat_cnt      (beat_cnt),
    .pkt_cnt       (pkt_cnt)
`endif
  );

  // Scoreboard: writes pop the oldest accepted beat; accepts push; reset drops everything.
  always @(negedge w_clk) begin
    logic [FW:0] exp_w;
    if (wr_en === 1'b1) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write w_data=%h expected no write", w_data);
      end else begin
        exp_w = sb.pop_front();
        if (w_data !== exp_w) begin
          errors++;
          $display("FAIL sb_data got=%h exp=%h", w_data, exp_w);
        end
      end
    end
    if (!rst && s_axis_tvalid && s_axis_tready === 1'b1)
      sb.push_back({s_axis_tlast, s_axis_tdata});
    if (rst) sb.delete();
    if (sb.size() > max_sb) max_sb = sb.size();
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [FW-1:0] d, input logic l);
    bit ok;
    ok = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge w_clk);
      if (s_axis_tready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h got no tready exp tready=1", d);
    end
    @(posedge w_clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA5;
    s_axis_tlast  = 1'b1;
    repeat (3) begin
      @(negedge w_clk);
      checks++;
      if (s_axis_tready !== 1'b0 || wr_en !== 1'b0 || w_data !== '0) begin
        errors++;
        $display("FAIL reset_hold tready=%b wr_en=%b w_data=%h exp 0/0/0", s_axis_tready, wr_en, w_data);
      end
    end
    @(posedge w_clk); #1;
    rst = 1'b0;
    @(negedge w_clk);
    checks++;
    if (s_axis_tready !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel1 tready=%b wr_en=%b exp 0/0", s_axis_tready, wr_en);
    end
    @(negedge w_clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rel2 tready=%b exp 1", s_axis_tready);
    end
    @(posedge w_clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL first_latency wr_en=%b exp 1", wr_en);
    end
    drain(2);
  endtask

  task automatic test_stream;
    full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata  = i;
      s_axis_tlast  = (i == 7);
      s_axis_tvalid = 1'b1;
      @(negedge w_clk);
      checks++;
      if (s_axis_tready !== 1'b1 || wr_en !== (i > 0)) begin
        errors++;
        $display("FAIL stream_beat%0d tready=%b wr_en=%b exp 1/%b", i, s_axis_tready, wr_en, (i > 0));
      end
      @(posedge w_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b1 || w_data !== {1'b1, 32'h7}) begin
      errors++;
      $display("FAIL stream_last wr_en=%b w_data=%h exp 1/%h", wr_en, w_data, {1'b1, 32'h7});
    end
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_end wr_en=%b sb=%0d exp 0/0", wr_en, sb.size());
    end
    drain(1);
  endtask

  task automatic test_backpressure;
    full = 1'b0;
    s_axis_tdata = 32'h100; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    @(negedge w_clk);
    @(posedge w_clk); #1;
    full = 1'b1;
    s_axis_tdata = 32'h101;
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one wr_en=%b tready=%b exp 0/1", wr_en, s_axis_tready);
    end
    @(posedge w_clk); #1;
    s_axis_tdata = 32'h102;
    for (int c = 0; c < 5; c++) begin
      @(negedge w_clk);
      checks++;
      if (s_axis_tready !== 1'b0 || wr_en !== 1'b0 || w_data !== {1'b0, 32'h100}) begin
        errors++;
        $display("FAIL bp_stall%0d tready=%b wr_en=%b w_data=%h exp 0/0/%h", c, s_axis_tready, wr_en, w_data, {1'b0, 32'h100});
      end
      @(posedge w_clk); #1;
    end
    full = 1'b0;
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release wr_en=%b tready=%b exp 1/0", wr_en, s_axis_tready);
    end
    @(negedge w_clk);
    checks++;
    if (s_axis_tready !== 1'b1 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL bp_recover tready=%b wr_en=%b exp 1/1", s_axis_tready, wr_en);
    end
    @(posedge w_clk); #1;
    s_axis_tvalid = 1'b0;
    drain(4);
    checks++;
    if (sb.size() != 0 || max_sb != 2) begin
      errors++;
      $display("FAIL bp_drain sb=%0d max=%0d exp 0/2", sb.size(), max_sb);
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    max_sb = 0;
    w0 = writes;
    full = 1'b0;
    fork
      begin
        repeat (60) begin
          @(posedge w_clk); #1;
          full = ~full;
        end
      end
      begin
        for (int i = 0; i < 12; i++) send($urandom, (i % 4) == 3);
      end
    join
    full = 1'b0;
    drain(4);
    checks++;
    if (sb.size() != 0 || max_sb > 2 || writes - w0 != 12) begin
      errors++;
      $display("FAIL simul sb=%0d max=%0d writes=%0d exp 0/<=2/12", sb.size(), max_sb, writes - w0);
    end
  endtask

  task automatic test_framing;
    logic exp_open[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic last_v[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    full = 1'b0;
    @(posedge w_clk); #1;
    rst = 1'b1;
    @(posedge w_clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'h200 + i, last_v[i]);
      @(negedge w_clk);
      checks++;
      if (pkt_open !== exp_open[i]) begin
        errors++;
        $display("FAIL framing_beat%0d pkt_open=%b exp %b", i, pkt_open, exp_open[i]);
      end
    end
`ifdef AXIS_WR_STATS_EN
    checks++;
    if (beat_cnt !== 16'd5 || pkt_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stats beat_cnt=%0d pkt_cnt=%0d exp 5/3", beat_cnt, pkt_cnt);
    end
`endif
    drain(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL framing_drain sb=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_mid_reset;
    full = 1'b1;
    send(32'h300, 1'b0);
    send(32'h301, 1'b0);
    @(negedge w_clk);
    checks++;
    if (pkt_open !== 1'b1 || s_axis_tready !== 1'b0 || sb.size() != 2) begin
      errors++;
      $display("FAIL midrst_pre pkt_open=%b tready=%b sb=%0d exp 1/0/2", pkt_open, s_axis_tready, sb.size());
    end
    @(posedge w_clk); #1;
    rst = 1'b1;
    @(posedge w_clk); #1;
    rst = 1'b0;
    full = 1'b0;
    @(negedge w_clk);
    checks++;
    if (wr_en !== 1'b0 || pkt_open !== 1'b0 || w_data !== '0) begin
      errors++;
      $display("FAIL midrst_post wr_en=%b pkt_open=%b w_data=%h exp 0/0/0", wr_en, pkt_open, w_data);
    end
    drain(3);
    send(32'h310, 1'b1);
    drain(3);
    checks++;
    if (sb.size() != 0 || pkt_open !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart sb=%0d pkt_open=%b exp 0/0", sb.size(), pkt_open);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_framing();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fifo_wr_if.md
Name: axis_fifo_wr_if

Overview:
- AXI4-Stream slave ingress stage that sits directly upstream of the FIFO write-side pointer logic, in the write clock domain.
- Accepts s_axis beats, holds them in a 2-entry skid buffer, and drives wr_en and w_data into the write-pointer logic and RAM using that logic's combinational full.
- s_axis_tready is fully registered, so the slave handshake has no combinational path from full or from the synchronized read pointer.
- Also tracks packet framing (tlast) and packs it into the stored word.

Parameters:
- FIFO_WIDTH, 32, AXIS tdata width in bits.
- CNT_WIDTH, 16, width of the optional statistics counters.

Ports:
- w_clk  input  1  write-domain clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  FIFO_WIDTH  stream payload.
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tlast  input  1  last beat of packet.
- s_axis_tready  output  1  registered ready to upstream.
- full  input  1  FIFO full, from the write-pointer logic (combinational).
- wr_en  output  1  write strobe to the write-pointer logic and RAM.
- w_data  output  FIFO_WIDTH+1  word to RAM; bit FIFO_WIDTH = tlast, bits [FIFO_WIDTH-1:0] = tdata.
- pkt_open  output  1  high between an accepted non-last beat and the next accepted tlast beat.
- beat_cnt  output  CNT_WIDTH  accepted beats (only with AXIS_WR_STATS_EN).
- pkt_cnt  output  CNT_WIDTH  accepted tlast beats (only with AXIS_WR_STATS_EN).

Behaviour:
- Clock and reset: single clock w_clk; reset rst is synchronous and active-high. While rst=1 at a clock edge, all state clears: buffer count=0, s_axis_tready=0, pkt_open=0, counters=0. Consequently wr_en=0 and w_data=0.
- Definitions:
  - accept = s_axis_tvalid & s_axis_tready.
  - pop = wr_en = (count != 0) & !full.
- Buffer states: EMPTY (count 0), ONE (count 1), TWO (count 2).
  - count_next = count + accept - pop; it never exceeds 2 and never goes below 0.
  - Transitions:
    - EMPTY -> ONE on accept.
    - ONE -> TWO on accept & !pop.
    - ONE -> EMPTY on pop & !accept.
    - TWO -> ONE on pop.
    - Otherwise the state holds.
- Ready:
  - s_axis_tready <= (count_next < 2) & !rst.
  - The first cycle after rst deasserts has tready=0; tready=1 from the following cycle.
- Ordering: strict FIFO. w_data is always the head (oldest) entry and is 0 when count=0.
- Simultaneous accept and pop:
  - In ONE, head is replaced by the new beat.
  - In TWO, tail shifts to head (accept is impossible in TWO).
- Latency: a beat accepted at edge N into EMPTY is presented with wr_en=1 in cycle N+1 if full=0. Throughput is 1 beat/cycle while full=0.
- Full asserted:
  - wr_en=0 and data holds.
  - The buffer fills to TWO, after which tready drops the next cycle; no beat is lost.
- Full falls: wr_en rises in the same cycle (combinational). tready recovers the cycle after count_next<2.
- pkt_open:
  - Set on accept with tlast=0.
  - Cleared on accept with tlast=1.
  - A single-beat packet leaves it 0.
- Reset mid-packet: buffered beats are discarded and pkt_open clears. Upstream must restart the packet.
- Protocol: tdata/tlast are sampled only on accept; tvalid may toggle freely.

Optional Feature:
- Macro: AXIS_WR_STATS_EN.
- Defined:
  - beat_cnt increments on every accept; pkt_cnt increments on every accept with tlast=1.
  - Both wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: beat_cnt and pkt_cnt ports are absent and no counter flops are built.

Decomposition:
- Shared package axis_fifo_pkg:
  - typedef buf_state_t enum {EMPTY, ONE, TWO}.
  - localparam TLAST_BIT (equal to FIFO_WIDTH).
  - function pack_word(tdata, tlast).
- One natural sub-module, axis_skid_buf:
  - Holds the 2-entry storage, the count/state and registered ready.
  - Parameterised by word width FIFO_WIDTH+1.
- The top level adds packing, pkt_open and the optional counters.

Test Plan:
- Reset release: hold rst=1 for 3 cycles, tvalid=1 -> tready=0 and wr_en=0 throughout; tready=0 in the first cycle after release and 1 in the second; no accept occurs before that.
- Streaming: full=0, send 8 beats 0x0..0x7 back-to-back with tlast on 0x7 -> wr_en high for 8 consecutive cycles starting 1 cycle after the first accept; w_data[31:0]=0..7 in order; w_data[32]=1 only on 0x7.
- Backpressure: full=1 from the 2nd beat onward -> exactly 2 beats buffered, tready=0 thereafter; drop full after 5 cycles -> wr_en=1 that same cycle, order preserved, no loss or duplication.
- Simultaneous push/pop: full toggles every cycle with tvalid=1 -> the scoreboard matches the input sequence exactly and count never exceeds 2.
- Framing: packets of lengths 1, 3 and 1 -> pkt_open stays 0 for the single-beat packets and is high after beats 1–2 of the 3-beat packet; with AXIS_WR_STATS_EN, beat_cnt=5 and pkt_cnt=3.
- Mid-packet reset: rst pulsed for 1 cycle after beat 2 of a 4-beat packet, with 2 beats buffered -> wr_en=0 and pkt_open=0 the next cycle; buffered beats are never written.
